// File: rtl/vga_timing_gen_if.sv
// Raster timing outputs of vga_timing_gen: sync pulses, visible-area flag,
// end-of-frame strobe and current pixel coordinates.
interface vga_timing_gen_if;
  logic       hSync;
  logic       vSync;
  logic       active;
  logic       screenEnd;
  logic [9:0] x;
  logic [9:0] y;

  modport master (
    output hSync,
    output vSync,
    output active,
    output screenEnd,
    output x,
    output y
  );

  modport slave (
    input hSync,
    input vSync,
    input active,
    input screenEnd,
    input x,
    input y
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator. The two counters are the only state;
// every output is a combinational decode of them (zero latency).
module vga_timing_gen #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic             clk25,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

  // Window bounds are 11 bits so an end bound equal to 1024 still compares correctly.
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(WIDTH);
  localparam logic [10:0] V_VIS    = 11'(HEIGHT);
  localparam logic [10:0] HS_START = 11'(WIDTH + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(HEIGHT + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(HEIGHT + V_FRONT + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("vga_timing_gen: raster does not fit 10-bit counters");
  end

  logic [9:0] h_count;
  logic [9:0] v_count;
  logic [9:0] h_next;
  logic [9:0] v_next;

  always_comb begin
    h_next = h_count + 10'd1;
    v_next = v_count;
    if (h_count == H_LAST) begin
      h_next = '0;
      if (v_count == V_LAST) begin
        v_next = '0;
      end else begin
        v_next = v_count + 10'd1;
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else begin
      h_count <= h_next;
      v_count <= v_next;
    end
  end

  logic h_in_sync;
  logic v_in_sync;

  assign h_in_sync = ({1'b0, h_count} >= HS_START) && ({1'b0, h_count} < HS_END);
  assign v_in_sync = ({1'b0, v_count} >= VS_START) && ({1'b0, v_count} < VS_END);

  assign vga.hSync     = h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vga.vSync     = v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vga.active    = ({1'b0, h_count} < H_VIS) && ({1'b0, v_count} < V_VIS);
  assign vga.screenEnd = (h_count == H_LAST) && (v_count == V_LAST);
  assign vga.x         = h_count;
  assign vga.y         = v_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three raster geometries driven from one clock and reset,
// compared every cycle against a model that derives position from clocks since reset.
module tb_vga_timing_gen;

  logic clk25 = 1'b0;
  logic reset = 1'b1;
  bit   checking = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_cyc = 0;

  always #5 clk25 = ~clk25;

  vga_timing_gen_if vif0 ();
  vga_timing_gen_if vif1 ();
  vga_timing_gen_if vif2 ();

  vga_timing_gen u_dut0 (
    .clk25 (clk25),
    .reset (reset),
    .vga   (vif0.master)
  );

  vga_timing_gen #(
    .WIDTH (8), .HEIGHT (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
    .V_FRONT (1), .V_SYNC (1), .V_BACK (1), .SYNC_ACTIVE (1'b0)
  ) u_dut1 (
    .clk25 (clk25),
    .reset (reset),
    .vga   (vif1.master)
  );

  vga_timing_gen #(
    .WIDTH (20), .HEIGHT (6), .H_FRONT (3), .H_SYNC (5), .H_BACK (2),
    .V_FRONT (2), .V_SYNC (3), .V_BACK (1), .SYNC_ACTIVE (1'b1)
  ) u_dut2 (
    .clk25 (clk25),
    .reset (reset),
    .vga   (vif2.master)
  );

  // clocks elapsed since the last edge that sampled reset high
  always @(posedge clk25) begin
    if (reset) n_cyc <= 0;
    else       n_cyc <= n_cyc + 1;
  end

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       se;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  function automatic exp_t ref_out(int n, int w, int h, int hf, int hsw, int hb,
                                   int vf, int vsw, int vb, logic sa);
    exp_t e;
    int ht, vt, px, ln;
    ht = w + hf + hsw + hb;
    vt = h + vf + vsw + vb;
    px = n % ht;
    ln = (n / ht) % vt;
    e.x   = 10'(px);
    e.y   = 10'(ln);
    e.act = (px < w) && (ln < h);
    e.hs  = (px >= w + hf && px < w + hf + hsw) ? sa : ~sa;
    e.vs  = (ln >= h + vf && ln < h + vf + vsw) ? sa : ~sa;
    e.se  = (px == ht - 1) && (ln == vt - 1);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, n_cyc);
  endtask

  task automatic cmp_dut(input string tag, input exp_t e, input logic hs, input logic vs,
                         input logic act, input logic se, input logic [9:0] x,
                         input logic [9:0] y);
    check({tag, ".x"},         32'(x),   32'(e.x));
    check({tag, ".y"},         32'(y),   32'(e.y));
    check({tag, ".active"},    32'(act), 32'(e.act));
    check({tag, ".hSync"},     32'(hs),  32'(e.hs));
    check({tag, ".vSync"},     32'(vs),  32'(e.vs));
    check({tag, ".screenEnd"}, 32'(se),  32'(e.se));
  endtask

  task automatic compare_all();
    cmp_dut("d0", ref_out(n_cyc, 640, 480, 16, 96, 48, 10, 2, 33, 1'b0),
            vif0.hSync, vif0.vSync, vif0.active, vif0.screenEnd, vif0.x, vif0.y);
    cmp_dut("d1", ref_out(n_cyc, 8, 4, 1, 1, 1, 1, 1, 1, 1'b0),
            vif1.hSync, vif1.vSync, vif1.active, vif1.screenEnd, vif1.x, vif1.y);
    cmp_dut("d2", ref_out(n_cyc, 20, 6, 3, 5, 2, 2, 3, 1, 1'b1),
            vif2.hSync, vif2.vSync, vif2.active, vif2.screenEnd, vif2.x, vif2.y);
  endtask

  task automatic tick();
    @(negedge clk25);
    if (checking) compare_all();
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk25);
    reset = 1'b0;
    checking = 1'b1;
    compare_all();
    // explicit post-reset values at the default geometry
    check("rst.x",      32'(vif0.x),      32'd0);
    check("rst.y",      32'(vif0.y),      32'd0);
    check("rst.active", 32'(vif0.active), 32'd1);
    check("rst.hSync",  32'(vif0.hSync),  32'd1);
    check("rst.vSync",  32'(vif0.vSync),  32'd1);
    tick();
    check("rel.x1", 32'(vif0.x), 32'd1);
    repeat (1700) tick();
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(1, 3000)) tick();
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      reset = 1'b0;
    end
    repeat (200) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Free-running VGA raster timing generator clocked by the 25 MHz pixel clock. It produces the horizontal and vertical sync pulses, a display-active flag, a one-cycle end-of-frame strobe, and the current pixel coordinates. The VGA controller uses the coordinates to address the background image RAM and to overlay sprites, and blanks colour whenever active is low.

Parameters:
WIDTH, 640, visible pixels per line
HEIGHT, 480, visible lines per frame
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, logic level of hSync/vSync during the pulse (0 = negative sync)

Ports:
clk25  input  1  pixel clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
hSync  output  1  horizontal sync
vSync  output  1  vertical sync
active  output  1  high while the current pixel is inside the visible area
screenEnd  output  1  one-cycle strobe on the last pixel of each frame
x  output  10  horizontal counter value, 0 at the left edge
y  output  10  vertical counter value, 0 at the top line

Behaviour:
- H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK (defaults to 800). V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK (defaults to 525).
- Reset is synchronous and active-high, sampled on the rising edge of clk25. While reset is high, hCount and vCount are set to 0.
- Outputs after reset (counters at 0,0): x=0, y=0, active=1, hSync=vSync=!SYNC_ACTIVE, screenEnd=0.
- hCount increments by 1 every clock.
  - At hCount=H_TOTAL-1, hCount wraps to 0 and vCount increments.
  - When vCount=V_TOTAL-1 also holds, vCount wraps to 0.
- The counters are the only state. All outputs are combinational decodes of the registered counters, so they have zero latency relative to the counters.
- x = hCount and y = vCount, including during blanking (x ranges 0..H_TOTAL-1, y ranges 0..V_TOTAL-1). Downstream logic must qualify pixels with active.
- active = (hCount < WIDTH) && (vCount < HEIGHT).
- hSync = SYNC_ACTIVE when WIDTH+H_FRONT <= hCount < WIDTH+H_FRONT+H_SYNC (defaults: 656..751); otherwise !SYNC_ACTIVE.
- vSync = SYNC_ACTIVE when HEIGHT+V_FRONT <= vCount < HEIGHT+V_FRONT+V_SYNC (defaults: 490..491); otherwise !SYNC_ACTIVE. vSync depends only on vCount, so it changes on line boundaries (hCount=0).
- screenEnd = 1 exactly when hCount=H_TOTAL-1 and vCount=V_TOTAL-1. This gives one cycle per frame (every 420000 clocks at defaults), immediately before the pixel (0,0).
- Reset asserted mid-frame: the counters return to (0,0) on the next edge. There is no partial sync pulse extension; hSync and vSync deassert immediately if the counters leave the sync window.
- Width rules:
  - Counters must be wide enough for H_TOTAL-1 and V_TOTAL-1 (10 bits at defaults).
  - x and y are zero-extended when connected to wider buses.

Test Plan:
- Reset held 3 cycles, then released -> x=0, y=0, active=1, hSync=1, vSync=1, screenEnd=0; x=1 one cycle after release.
- Run one full line from reset -> active high for cycles 0..639 and low for 640..799; hSync low exactly at x=656..751 (96 cycles); at x=799 the next clock gives x=0, y=1.
- Run to y=480 -> active low for the whole line even when x<640; vSync low for lines 490 and 491 only (1600 cycles); vSync high again at y=492.
- Run two full frames -> screenEnd pulses exactly at (799,524), with pulses 420000 cycles apart; the cycle after each pulse shows x=0, y=0.
- Assert reset at (300,200) for one cycle -> the next cycle shows (0,0); subsequent timing is identical to a fresh start.
- Instantiate with WIDTH=8, HEIGHT=4, H_FRONT=H_SYNC=H_BACK=1, V_FRONT=V_SYNC=V_BACK=1 -> H_TOTAL=11, V_TOTAL=7; hSync pulses at x=9; vSync at y=5; screenEnd at (10,6).
